rr_mux_stage: RTL and testbench
===============================

Name: rr_mux_stage

Overview:
- Parametrised successor to the team's fixed 3-way combinational selector.
- Merges CH producer channels of width n onto one output through a registered valid/ready pipeline stage, with selectable round-robin or fixed-priority arbitration.
- Used where several datapath sources compete for one consumer, for example writeback-port sharing or memory-request merging, and a combinational select cannot meet timing or fairness needs.

Parameters:
- n, 32, data width per channel in bits.
- CH, 3, number of input channels; legal range 2..8.
- SW, 2, width of the channel index; must satisfy 2^SW >= CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  CH  per-channel request; bit i belongs to channel i.
- in_data  input  CH*n  packed channel data; channel i occupies bits [i*n+n-1 : i*n].
- in_ready  output  CH  per-channel grant/accept, one-hot or zero.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_valid  output  1  output register holds a valid word.
- out_data  output  n  registered selected data.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: asynchronous and active-high.
  - While rst=1: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready is 0 while rst=1.
  - Asserting reset mid-transfer discards the held word with no output handshake.
- Stage state: a single output register, either EMPTY (out_valid=0) or FULL (out_valid=1).
- can_load = !out_valid || out_ready.
- Arbitration is combinational, each cycle, over in_valid:
  - Round-robin (prio_mode=0): scan from index ptr upward with wrap mod CH; the first set bit wins.
  - Fixed priority (prio_mode=1): the lowest set index wins; ptr is ignored but retained.
- in_ready[g]=1 only for the winner g, and only when can_load=1. All other bits are 0.
  - No valid inputs or can_load=0 gives in_ready=0.
  - in_ready depends combinationally on in_valid, out_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on channel g occurs when in_valid[g] && in_ready[g] at a rising edge. At that edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - in round-robin mode only, ptr <= (g == CH-1) ? 0 : g+1
- Output handshake: a word leaves when out_valid && out_ready at the edge.
  - If no new transfer occurs at that same edge, out_valid <= 0.
  - out_data and out_sel hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge with no bubble, giving full throughput of 1 word/cycle.
- Stall: out_valid=1 && out_ready=0 → out_data, out_sel and ptr hold; in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Fairness: in round-robin mode, with all CH channels continuously valid and out_ready=1, grants cycle 0,1,...,CH-1,0,...
- Changing prio_mode: takes effect on the next arbitration. ptr is not reset.
- No data path arithmetic. out_data is bit-exact with the selected channel's in_data.

Test Plan (n=32, CH=3):
- Reset: assert rst asynchronously mid-cycle while out_valid=1 → out_valid, out_data, out_sel go to 0 immediately; in_ready=000.
- Single channel: in_valid=010, in_data ch1=0xDEADBEEF, out_ready=1 → in_ready=010; the next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=1.
- Round-robin fairness: in_valid=111 held, data ch0/1/2 = 0x10/0x20/0x30, prio_mode=0, out_ready=1 → out_sel sequence 0,1,2,0,1,2 and out_data 0x10,0x20,0x30,... every cycle with no bubbles.
- Fixed priority: in_valid=110, prio_mode=1 → ch1 always wins (out_sel=1, in_ready=010). Then drop ch1 → ch2 wins.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles with in_valid=111 → in_ready=000; out_data/out_sel stable; no channel is lost. On out_ready=1 the next grant follows the ptr order.
- Wrap and mode switch: a ch2 grant in round-robin gives ptr=0. Switch to prio_mode=1 for two grants, then back to 0 → the round-robin scan resumes from the retained ptr.

Source files
------------

// File: rtl/rr_mux_stage.sv
// Merges CH valid/ready producer channels onto one registered output stage
// with selectable round-robin or fixed-priority (lowest index) arbitration.
module rr_mux_stage #(
    parameter int unsigned n  = 32,
    parameter int unsigned CH = 3,
    parameter int unsigned SW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*n-1:0] in_data,
    output logic [CH-1:0]   in_ready,
    input  logic            prio_mode,
    output logic            out_valid,
    output logic [n-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          can_load;
    logic          load;
    logic [SW-1:0] scan_idx;
    logic [n-1:0]  ch_data [CH];

    // Unpack the flat channel bus so the selected word can be indexed directly.
    for (genvar i = 0; i < CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*n +: n];
    end

    assign out_valid = (state == FULL);
    assign can_load  = !out_valid || out_ready;
    assign load      = grant_any && can_load;

    // Arbiter: scan in reverse so the highest-precedence candidate is written last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (prio_mode) begin
            for (int i = int'(CH) - 1; i >= 0; i--) begin
                if (in_valid[SW'(i)]) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int k = int'(CH) - 1; k >= 0; k--) begin
                scan_idx = SW'((int'(ptr) + k) % int'(CH));
                if (in_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && !rst) begin
            in_ready = CH'(1) << grant_idx;
        end
    end

    // Stage occupancy: a load always leaves the register full, a bare drain empties it.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                if (!load && out_ready) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Payload and round-robin pointer; the pointer only advances on round-robin grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (load) begin
            out_data <= ch_data[grant_idx];
            out_sel  <= grant_idx;
            if (!prio_mode) begin
                ptr <= (grant_idx == SW'(CH - 1)) ? '0 : SW'(grant_idx + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed bench for rr_mux_stage: reset, single channel, round-robin fairness,
// fixed priority, backpressure, pointer retention across mode switches.
module tb_rr_mux_stage;

    localparam int unsigned N  = 32;
    localparam int unsigned CH = 3;
    localparam int unsigned SW = 2;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   in_valid;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_ready;
    logic            prio_mode;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready;

    int checks;
    int errors;

    rr_mux_stage #(.n(N), .CH(CH), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .prio_mode (prio_mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [SW-1:0] s,
                             input logic [N-1:0] d);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check({tag, ".out_sel"},   64'(out_sel),   64'(s));
        check({tag, ".out_data"},  64'(out_data),  64'(d));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 3'b111;
        in_data   = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
        prio_mode = 1'b0;
        out_ready = 1'b1;

        // Reset holds everything at zero even with requests present.
        tick();
        tick();
        check("reset.in_ready", 64'(in_ready), 64'(3'b000));
        check_out("reset", 1'b0, 2'd0, 32'h0);
        rst = 1'b0;
        in_valid = 3'b000;
        tick();

        // Single channel 1.
        in_valid = 3'b010;
        in_data  = {32'h0000_0030, 32'hDEAD_BEEF, 32'h0000_0010};
        #1;
        check("single.in_ready", 64'(in_ready), 64'(3'b010));
        tick();
        check_out("single", 1'b1, 2'd1, 32'hDEAD_BEEF);
        in_valid = 3'b000;
        #1;
        check("idle.in_ready", 64'(in_ready), 64'(3'b000));
        tick();
        check_out("drain", 1'b0, 2'd1, 32'hDEAD_BEEF);

        // Channel 2 grant wraps ptr back to 0.
        in_data  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
        in_valid = 3'b100;
        #1;
        check("wrap.in_ready", 64'(in_ready), 64'(3'b100));
        tick();
        check_out("wrap", 1'b1, 2'd2, 32'h30);

        // Round-robin fairness, back to back with no bubbles.
        in_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d.in_ready", i), 64'(in_ready), 64'(3'b001 << (i % 3)));
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, SW'(i % 3), N'(((i % 3) + 1) * 16));
        end

        // Fixed priority: ch1 beats ch2, then ch2 alone.
        prio_mode = 1'b1;
        in_valid  = 3'b110;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("fp%0d.in_ready", i), 64'(in_ready), 64'(3'b010));
            tick();
            check_out($sformatf("fp%0d", i), 1'b1, 2'd1, 32'h20);
        end
        in_valid = 3'b100;
        #1;
        check("fp_ch2.in_ready", 64'(in_ready), 64'(3'b100));
        tick();
        check_out("fp_ch2", 1'b1, 2'd2, 32'h30);

        // Backpressure: stage holds, nothing granted.
        prio_mode = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'(3'b000));
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 2'd2, 32'h30);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 64'(in_ready), 64'(3'b001));
        tick();
        check_out("bp_release", 1'b1, 2'd0, 32'h10);

        // Advance ptr to 2, then fixed-priority grants must leave it alone.
        #1;
        check("rr_ch1.in_ready", 64'(in_ready), 64'(3'b010));
        tick();
        check_out("rr_ch1", 1'b1, 2'd1, 32'h20);
        prio_mode = 1'b1;
        in_valid  = 3'b100;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out($sformatf("sw%0d", i), 1'b1, 2'd2, 32'h30);
        end
        prio_mode = 1'b0;
        in_valid  = 3'b111;
        #1;
        check("resume.in_ready", 64'(in_ready), 64'(3'b100));
        tick();
        check_out("resume", 1'b1, 2'd2, 32'h30);
        #1;
        check("resume_wrap.in_ready", 64'(in_ready), 64'(3'b001));
        tick();
        check_out("resume_wrap", 1'b1, 2'd0, 32'h10);

        // Mid-cycle asynchronous reset discards the held word and clears ptr.
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 2'd0, 32'h0);
        check("async_rst.in_ready", 64'(in_ready), 64'(3'b000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'(3'b001));
        tick();
        check_out("post_rst", 1'b1, 2'd0, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
